// File: rtl/axil_master_port_if.sv
// AXI4-Lite bus bundle between axil_master_port (master modport) and an AXI4-Lite slave.
interface axil_master_port_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXIL_AWADDR;
  logic                  M_AXIL_AWVALID;
  logic                  M_AXIL_AWREADY;
  logic [31:0]           M_AXIL_WDATA;
  logic [3:0]            M_AXIL_WSTRB;
  logic                  M_AXIL_WVALID;
  logic                  M_AXIL_WREADY;
  logic [1:0]            M_AXIL_BRESP;
  logic                  M_AXIL_BVALID;
  logic                  M_AXIL_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXIL_ARADDR;
  logic                  M_AXIL_ARVALID;
  logic                  M_AXIL_ARREADY;
  logic [31:0]           M_AXIL_RDATA;
  logic [1:0]            M_AXIL_RRESP;
  logic                  M_AXIL_RVALID;
  logic                  M_AXIL_RREADY;

  modport master (
    output M_AXIL_AWADDR, M_AXIL_AWVALID, M_AXIL_WDATA, M_AXIL_WSTRB, M_AXIL_WVALID,
           M_AXIL_BREADY, M_AXIL_ARADDR, M_AXIL_ARVALID, M_AXIL_RREADY,
    input  M_AXIL_AWREADY, M_AXIL_WREADY, M_AXIL_BRESP, M_AXIL_BVALID,
           M_AXIL_ARREADY, M_AXIL_RDATA, M_AXIL_RRESP, M_AXIL_RVALID
  );

  modport slave (
    input  M_AXIL_AWADDR, M_AXIL_AWVALID, M_AXIL_WDATA, M_AXIL_WSTRB, M_AXIL_WVALID,
           M_AXIL_BREADY, M_AXIL_ARADDR, M_AXIL_ARVALID, M_AXIL_RREADY,
    output M_AXIL_AWREADY, M_AXIL_WREADY, M_AXIL_BRESP, M_AXIL_BVALID,
           M_AXIL_ARREADY, M_AXIL_RDATA, M_AXIL_RRESP, M_AXIL_RVALID
  );
endinterface

// File: rtl/axil_master_port.sv
// Single-outstanding command/response to AXI4-Lite initiator.
// Optional slave-stall abort: define AXIL_MASTER_TIMEOUT_EN.
module axil_master_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axil_master_port_if.master    m_axil
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                state_r, state_n;
  logic                  awvalid_r, awvalid_n;
  logic                  wvalid_r, wvalid_n;
  logic                  bready_r, bready_n;
  logic                  arvalid_r, arvalid_n;
  logic                  rready_r, rready_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [31:0]           wdata_r, wdata_n;
  logic [3:0]            wstrb_r, wstrb_n;
  logic [31:0]           rsp_rdata_r, rsp_rdata_n;
  logic [1:0]            rsp_resp_r, rsp_resp_n;
  logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_r, timer_n;
  logic          rsp_timeout_r, rsp_timeout_n;
  logic          busy_s, hs_any_s;
`endif

  assign aw_hs_s = awvalid_r & m_axil.M_AXIL_AWREADY;
  assign w_hs_s  = wvalid_r  & m_axil.M_AXIL_WREADY;
  assign b_hs_s  = bready_r  & m_axil.M_AXIL_BVALID;
  assign ar_hs_s = arvalid_r & m_axil.M_AXIL_ARREADY;
  assign r_hs_s  = rready_r  & m_axil.M_AXIL_RVALID;

  // Next-state and next-register decode for the transaction FSM
  always_comb begin
    state_n     = state_r;
    awvalid_n   = awvalid_r;
    wvalid_n    = wvalid_r;
    bready_n    = bready_r;
    arvalid_n   = arvalid_r;
    rready_n    = rready_r;
    addr_n      = addr_r;
    wdata_n     = wdata_r;
    wstrb_n     = wstrb_r;
    rsp_rdata_n = rsp_rdata_r;
    rsp_resp_n  = rsp_resp_r;
`ifdef AXIL_MASTER_TIMEOUT_EN
    rsp_timeout_n = rsp_timeout_r;
    timer_n       = timer_r;
    busy_s        = 1'b0;
    hs_any_s      = aw_hs_s | w_hs_s | b_hs_s | ar_hs_s | r_hs_s;
`endif
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          wstrb_n = cmd_wstrb;
`ifdef AXIL_MASTER_TIMEOUT_EN
          rsp_timeout_n = 1'b0;
`endif
          if (cmd_write) begin
            state_n   = WR_REQ;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_REQ;
            arvalid_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; neither waits on the other's READY
        awvalid_n = awvalid_r & ~aw_hs_s;
        wvalid_n  = wvalid_r & ~w_hs_s;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end else begin
          state_n = WR_REQ;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          rsp_resp_n  = m_axil.M_AXIL_BRESP;
          rsp_rdata_n = 32'h0000_0000;
          bready_n    = 1'b0;
          state_n     = RESP;
        end else begin
          state_n = WR_RESP;
        end
      end
      RD_REQ: begin
        if (ar_hs_s) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end else begin
          state_n = RD_REQ;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          rsp_rdata_n = m_axil.M_AXIL_RDATA;
          rsp_resp_n  = m_axil.M_AXIL_RRESP;
          rready_n    = 1'b0;
          state_n     = RESP;
        end else begin
          state_n = RD_DATA;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n   = IDLE;
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        bready_n  = 1'b0;
        arvalid_n = 1'b0;
        rready_n  = 1'b0;
      end
    endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
    busy_s = (state_r == WR_REQ) || (state_r == WR_RESP) ||
             (state_r == RD_REQ) || (state_r == RD_DATA);
    if (!busy_s || hs_any_s) begin
      timer_n = {TW{1'b0}};
    end else if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stall limit hit: withdraw from the bus and report SLVERR to the client
      timer_n       = {TW{1'b0}};
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_resp_n    = 2'b10;
      rsp_rdata_n   = 32'h0000_0000;
      rsp_timeout_n = 1'b1;
      state_n       = RESP;
    end else begin
      timer_n = timer_r + TW'(1);
    end
`endif
  end

  // State and datapath registers; async reset withdraws every VALID/READY at once
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= IDLE;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'h0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_resp_r  <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      timer_r       <= {TW{1'b0}};
      rsp_timeout_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      awvalid_r   <= awvalid_n;
      wvalid_r    <= wvalid_n;
      bready_r    <= bready_n;
      arvalid_r   <= arvalid_n;
      rready_r    <= rready_n;
      addr_r      <= addr_n;
      wdata_r     <= wdata_n;
      wstrb_r     <= wstrb_n;
      rsp_rdata_r <= rsp_rdata_n;
      rsp_resp_r  <= rsp_resp_n;
`ifdef AXIL_MASTER_TIMEOUT_EN
      timer_r       <= timer_n;
      rsp_timeout_r <= rsp_timeout_n;
`endif
    end
  end

  assign cmd_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_resp  = rsp_resp_r;
`ifdef AXIL_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_r;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign m_axil.M_AXIL_AWADDR  = addr_r;
  assign m_axil.M_AXIL_AWVALID = awvalid_r;
  assign m_axil.M_AXIL_WDATA   = wdata_r;
  assign m_axil.M_AXIL_WSTRB   = wstrb_r;
  assign m_axil.M_AXIL_WVALID  = wvalid_r;
  assign m_axil.M_AXIL_BREADY  = bready_r;
  assign m_axil.M_AXIL_ARADDR  = addr_r;
  assign m_axil.M_AXIL_ARVALID = arvalid_r;
  assign m_axil.M_AXIL_RREADY  = rready_r;

endmodule

// File: tb/tb_axil_master_port.sv
// Directed bench for axil_master_port against a small delay-programmable AXI4-Lite slave model.
module tb_axil_master_port;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;

  axil_master_port_if #(.ADDR_WIDTH(32)) bus ();

  axil_master_port #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK        (aclk),
    .ARESETN     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axil      (bus)
  );

  always #5 aclk = ~aclk;

  // Slave model knobs
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic       ar_enable = 1'b1;
  logic [1:0] b_resp_cfg = 2'b00;

  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_done, w_done, b_pend, r_pend;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic [31:0] mem [0:63];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  assign bus.M_AXIL_AWREADY = bus.M_AXIL_AWVALID && !aw_done && (aw_cnt >= aw_delay);
  assign bus.M_AXIL_WREADY  = bus.M_AXIL_WVALID && !w_done && (w_cnt >= w_delay);
  assign bus.M_AXIL_BVALID  = b_pend && (b_cnt >= b_delay);
  assign bus.M_AXIL_BRESP   = b_resp_cfg;
  assign bus.M_AXIL_ARREADY = bus.M_AXIL_ARVALID && ar_enable && !r_pend && (ar_cnt >= ar_delay);
  assign bus.M_AXIL_RVALID  = r_pend && (r_cnt >= r_delay);
  assign bus.M_AXIL_RDATA   = mem[ar_addr_q[7:2]];
  assign bus.M_AXIL_RRESP   = 2'b00;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_addr_q <= 32'h0; w_data_q <= 32'h0; w_strb_q <= 4'h0; ar_addr_q <= 32'h0;
    end else begin
      if (bus.M_AXIL_AWVALID && bus.M_AXIL_AWREADY) begin
        aw_done <= 1'b1; aw_addr_q <= bus.M_AXIL_AWADDR; aw_cnt <= 0;
      end else if (bus.M_AXIL_AWVALID && !aw_done) aw_cnt <= aw_cnt + 1;
      if (bus.M_AXIL_WVALID && bus.M_AXIL_WREADY) begin
        w_done <= 1'b1; w_data_q <= bus.M_AXIL_WDATA; w_strb_q <= bus.M_AXIL_WSTRB; w_cnt <= 0;
      end else if (bus.M_AXIL_WVALID && !w_done) w_cnt <= w_cnt + 1;
      if (!b_pend && (aw_done || bus.M_AXIL_AWREADY) && (w_done || bus.M_AXIL_WREADY)) begin
        b_pend <= 1'b1; b_cnt <= 0;
      end else if (b_pend && !bus.M_AXIL_BVALID) b_cnt <= b_cnt + 1;
      if (bus.M_AXIL_BVALID && bus.M_AXIL_BREADY) begin
        b_pend <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0;
      end
      if (bus.M_AXIL_ARVALID && bus.M_AXIL_ARREADY) begin
        r_pend <= 1'b1; ar_addr_q <= bus.M_AXIL_ARADDR; ar_cnt <= 0; r_cnt <= 0;
      end else if (bus.M_AXIL_ARVALID) ar_cnt <= ar_cnt + 1;
      if (r_pend && !bus.M_AXIL_RVALID) r_cnt <= r_cnt + 1;
      if (bus.M_AXIL_RVALID && bus.M_AXIL_RREADY) r_pend <= 1'b0;
    end
  end

  // Memory update on B handshake; cleared only at start of simulation
  always @(posedge aclk) begin
    if (bus.M_AXIL_BVALID && bus.M_AXIL_BREADY)
      mem[aw_addr_q[7:2]] <= merge(mem[aw_addr_q[7:2]], w_data_q, w_strb_q);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Presents a command, checks it is accepted at the next edge (T0), returns at T0+1
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_valids", {27'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID, bus.M_AXIL_BREADY,
                       bus.M_AXIL_ARVALID, bus.M_AXIL_RREADY}, 32'd0);
    chk("rst_rsp_data", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
    chk("rst_awaddr", bus.M_AXIL_AWADDR, 32'h0);
    aresetn = 1'b1;
    step();

    // Basic write, zero-wait slave
    issue(1'b1, 32'h0000_0045, 32'h0105_ABCD, 4'hF);
    chk("wr_t0_aw_w_valid", {30'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}, 32'd3);
    chk("wr_t0_awaddr", bus.M_AXIL_AWADDR, 32'h0000_0045);
    chk("wr_t0_wdata", bus.M_AXIL_WDATA, 32'h0105_ABCD);
    chk("wr_t0_wstrb", {28'd0, bus.M_AXIL_WSTRB}, 32'hF);
    chk("wr_t0_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("wr_t1_valids_low", {30'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}, 32'd0);
    chk("wr_t1_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd1);
    chk("wr_t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("wr_t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_t2_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("wr_t2_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_t2_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd0);
    step();
    chk("wr_t3_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    chk("wr_mem", mem[17], 32'h0105_ABCD);

    // Read-back
    issue(1'b0, 32'h0000_0045, 32'h0, 4'h0);
    chk("rd_t0_arvalid", {31'd0, bus.M_AXIL_ARVALID}, 32'd1);
    chk("rd_t0_araddr", bus.M_AXIL_ARADDR, 32'h0000_0045);
    step();
    chk("rd_t1_ar_r", {30'd0, bus.M_AXIL_ARVALID, bus.M_AXIL_RREADY}, 32'd1);
    step();
    chk("rd_t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_t2_rdata", rsp_rdata, 32'h0105_ABCD);
    chk("rd_t2_resp", {30'd0, rsp_resp}, 32'd0);
    step();

    // Skewed channels: AW late
    aw_delay = 4; w_delay = 0;
    issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
    step();
    chk("skew1_t1_w_done_aw_held", {30'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}, 32'd2);
    chk("skew1_t1_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd0);
    repeat (3) step();
    chk("skew1_t4_aw_held", {31'd0, bus.M_AXIL_AWVALID}, 32'd1);
    chk("skew1_t4_awaddr", bus.M_AXIL_AWADDR, 32'h0000_0008);
    chk("skew1_t4_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd0);
    step();
    chk("skew1_t5_aw_done", {30'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_BREADY}, 32'd1);
    wait_rsp("skew1_rsp_wait", 10);
    step();
    chk("skew1_mem", mem[2], 32'hDEAD_BEEF);

    // Skewed channels: W late, partial strobe onto an existing word
    aw_delay = 0; w_delay = 3;
    issue(1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3);
    step();
    chk("skew2_t1_aw_done_w_held", {30'd0, bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}, 32'd1);
    chk("skew2_t1_wdata", bus.M_AXIL_WDATA, 32'h1234_5678);
    repeat (3) step();
    chk("skew2_t4_w_done", {30'd0, bus.M_AXIL_WVALID, bus.M_AXIL_BREADY}, 32'd1);
    wait_rsp("skew2_rsp_wait", 10);
    step();
    chk("skew2_mem", mem[2], 32'hDEAD_5678);
    w_delay = 0;

    // Slow B with SLVERR, response held by client
    b_delay = 6; b_resp_cfg = 2'b10;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF);
    step();
    chk("slow_t1_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd1);
    repeat (3) step();
    chk("slow_t4_bready", {31'd0, bus.M_AXIL_BREADY}, 32'd1);
    chk("slow_t4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;
    wait_rsp("slow_rsp_wait", 10);
    chk("slow_resp", {30'd0, rsp_resp}, 32'd2);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("slow_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("slow_hold_resp", {30'd0, rsp_resp}, 32'd2);
      chk("slow_hold_blocked", {30'd0, cmd_ready, bus.M_AXIL_ARVALID}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("slow_consumed", {29'd0, cmd_ready, rsp_valid, bus.M_AXIL_ARVALID}, 32'd4);
    step();
    cmd_valid = 1'b0;
    chk("slow_next_accept", {31'd0, bus.M_AXIL_ARVALID}, 32'd1);
    b_delay = 0; b_resp_cfg = 2'b00;
    wait_rsp("slow_rd_wait", 10);
    chk("slow_rd_data", rsp_rdata, 32'hA5A5_A5A5);
    step();

    // Reset in the middle of a read
    ar_delay = 5;
    issue(1'b0, 32'h0000_0045, 32'h0, 4'h0);
    step();
    chk("mrst_arvalid_before", {31'd0, bus.M_AXIL_ARVALID}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mrst_async_drop", {30'd0, bus.M_AXIL_ARVALID, bus.M_AXIL_RREADY}, 32'd0);
    chk("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) step();
    aresetn = 1'b1;
    ar_delay = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst_no_rsp", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    end

    // Slave never accepts AR
    ar_enable = 1'b0;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    repeat (15) step();
    chk("to_t15_arvalid", {30'd0, bus.M_AXIL_ARVALID, rsp_valid}, 32'd2);
    step();
    chk("to_t16_arvalid", {31'd0, bus.M_AXIL_ARVALID}, 32'd0);
    chk("to_t16_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_t16_resp", {30'd0, rsp_resp}, 32'd2);
    chk("to_t16_flag", {31'd0, rsp_timeout}, 32'd1);
    chk("to_t16_rdata", rsp_rdata, 32'h0);
    step();
    ar_enable = 1'b1;
    issue(1'b0, 32'h0000_0045, 32'h0, 4'h0);
    chk("to_flag_cleared", {31'd0, rsp_timeout}, 32'd0);
    wait_rsp("to_recover_wait", 10);
    chk("to_recover_rdata", rsp_rdata, 32'h0105_ABCD);
    step();
`else
    repeat (1000) step();
    chk("nto_arvalid_held", {30'd0, bus.M_AXIL_ARVALID, rsp_valid}, 32'd2);
    chk("nto_flag", {31'd0, rsp_timeout}, 32'd0);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    ar_enable = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master_port.md
Name: axil_master_port

Overview:
- AXI4-Lite initiator that converts a simple single-outstanding command/response interface into AXI4-Lite read and write transactions.
- Counterpart of the team's AXI4-Lite memory slave; lets on-chip logic (DMA stubs, config sequencers) drive any M_AXIL_* slave without hand-rolled handshakes.
- One transaction in flight at a time. The response is held until the client consumes it.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and M_AXIL_AWADDR/ARADDR.
- TIMEOUT_CYCLES, 256, cycles without completing a channel handshake before abort (used only with the optional feature; must be ≥2).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unchanged.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_resp  out  2  captured BRESP/RRESP.
- rsp_timeout  out  1  transaction aborted by timeout.
- M_AXIL_AWADDR out ADDR_WIDTH; M_AXIL_AWVALID out 1; M_AXIL_AWREADY in 1.
- M_AXIL_WDATA out 32; M_AXIL_WSTRB out 4; M_AXIL_WVALID out 1; M_AXIL_WREADY in 1.
- M_AXIL_BRESP in 2; M_AXIL_BVALID in 1; M_AXIL_BREADY out 1.
- M_AXIL_ARADDR out ADDR_WIDTH; M_AXIL_ARVALID out 1; M_AXIL_ARREADY in 1.
- M_AXIL_RDATA in 32; M_AXIL_RRESP in 2; M_AXIL_RVALID in 1; M_AXIL_RREADY out 1.

Behaviour:
- **Clock and reset:** one clock, ACLK. ARESETN is asynchronous assert, active low, and is released synchronously by the environment.
- **Reset state:**
  - State is IDLE.
  - All M_AXIL_*VALID, BREADY and RREADY are 0.
  - Address, data, strobe and rsp_* registers are 0.
  - cmd_ready = 1, because it is decoded combinationally from state==IDLE.
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- **IDLE:**
  - On accept, latch addr/wdata/wstrb.
  - Go to WR_REQ if cmd_write, else RD_REQ.
  - AWVALID+WVALID (or ARVALID) go high the next cycle, registered. Accept-to-VALID latency is 1 cycle.
- **WR_REQ:**
  - AWVALID and WVALID deassert independently, on the clock edge where each sees its READY. Either handshake may complete first, or both may complete in the same cycle.
  - When both channels are done, go to WR_RESP.
  - Once VALID is asserted, it and its payload stay stable until the handshake (AXI rule).
- **WR_RESP:**
  - BREADY = 1, registered, asserted on state entry.
  - On BVALID&&BREADY: capture BRESP, clear rsp_rdata, drop BREADY, go to RESP.
- **RD_REQ:** ARVALID is held until ARREADY, then go to RD_DATA.
- **RD_DATA:**
  - RREADY = 1.
  - On RVALID&&RREADY: capture RDATA/RRESP, drop RREADY, go to RESP.
- **RESP:**
  - rsp_valid = 1, with rsp_* stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until IDLE is reached. The next command can therefore be accepted no earlier than the cycle after the rsp handshake.
- **Minimum latency, zero-wait slave, rsp_ready tied high:**
  - Write: accept T0, AW/W handshake T1, B handshake T2, rsp_valid T3.
  - Read: accept T0, AR handshake T1, R handshake T2, rsp_valid T3.
- **Error responses:** non-OKAY BRESP/RRESP is passed through unmodified. The block never retries.
- **Reset mid-transaction:** all VALID/READY outputs drop immediately (asynchronously). In-flight state is discarded and no response is generated.
- **Write channel ordering:** WVALID is never gated on AWREADY, and AWVALID is never gated on WREADY.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- **Defined:**
  - A counter clears on state entry and on every completed channel handshake. It increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, in the same edge:
    - deassert all M_AXIL VALID/READY;
    - set rsp_resp=2'b10 (SLVERR), rsp_timeout=1, rsp_rdata=0;
    - go to RESP.
  - rsp_timeout clears when the next command is accepted.
- **Undefined:** no counter logic; rsp_timeout is tied 0; the block waits on the slave indefinitely.

Test Plan:
- **Basic write:** zero-wait slave, write addr 0x00000045, data 0x0105ABCD, strb 0xF → AW/W VALID one cycle after accept; rsp_valid on T3 with rsp_resp=2'b00; slave memory word holds 0x0105ABCD.
- **Read-back:** read 0x00000045 after the above write → ARVALID on T1; rsp_rdata=0x0105ABCD, rsp_resp=2'b00, rsp_valid on T3.
- **Skewed write channels:** WREADY immediate, AWREADY delayed 4 cycles (then the reverse) → WVALID drops after 1 cycle while AWVALID holds with stable AWADDR; WR_RESP is entered only after both handshakes; write completes correctly.
- **Slow slave and held response:** BVALID delayed 6 cycles with BRESP=2'b10, and rsp_ready held low 3 cycles → BREADY is high throughout the wait; rsp_resp=2'b10 held stable; cmd_ready stays 0 until rsp is consumed; a second cmd_valid is not accepted meanwhile.
- **Reset during a read:** ARESETN low while ARVALID=1 → ARVALID/RREADY fall within the same cycle (async); after release, cmd_ready=1 and no rsp_valid appears.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** slave never asserts ARREADY → after 16 cycles ARVALID=0, rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1. With the macro undefined, ARVALID is still asserted at 1000 cycles.
